// File: rtl/draw_cmd_pkg.sv
// Shared opcode table, FSM state encoding and word-count lookup for the draw command decoder.
package draw_cmd_pkg;

   localparam int NUM_OPS = 8;

   localparam logic [7:0] OP_NOP         = 8'h00;
   localparam logic [7:0] OP_EODL        = 8'h0F;
   localparam logic [7:0] OP_SETFRAME    = 8'h20;
   localparam logic [7:0] OP_SETDRAWAREA = 8'h21;
   localparam logic [7:0] OP_SETFCOLOR   = 8'h22;
   localparam logic [7:0] OP_SETSRC      = 8'h23;
   localparam logic [7:0] OP_PATBLT      = 8'h81;
   localparam logic [7:0] OP_BITBLT      = 8'h82;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RDREQ,
      S_RDWAIT,
      S_EXEC,
      S_NEXT,
      S_ERR
   } state_t;

   // Total words including the header; 0 marks an unknown opcode.
   function automatic logic [1:0] op_words(input logic [7:0] opcode);
      logic [1:0] w;
      case (opcode)
         OP_NOP, OP_EODL:                               w = 2'd1;
         OP_SETFCOLOR:                                  w = 2'd2;
         OP_SETFRAME, OP_SETDRAWAREA, OP_SETSRC,
         OP_PATBLT, OP_BITBLT:                          w = 2'd3;
         default:                                       w = 2'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/draw_cmd_decoder.sv
// Pops command words from a non-FWFT FIFO, gathers arguments and issues one command per valid/ready transfer.
// Two cycles per word plus exec and next cycles; a stalled OP_READY holds the command and stops all pops.
module draw_cmd_decoder
   import draw_cmd_pkg::*;
(
   input  logic        CLK,
   input  logic        ARST,
   input  logic        SOFT_RST,
   input  logic        EXE,
   output logic        CMD_RD_EN,
   input  logic [31:0] CMD_RDATA,
   input  logic        CMD_EMPTY,
   output logic        OP_VALID,
   input  logic        OP_READY,
   output logic [7:0]  OP_CODE,
   output logic [31:0] OP_ARG0,
   output logic [31:0] OP_ARG1,
   output logic        DRAW_BUSY,
   output logic        DRAW_END,
   output logic        CMD_ERR
);

   state_t      state;
   state_t      next_state;
   logic [1:0]  idx;
   logic [1:0]  nwords;
   logic [1:0]  hdr_words;
   logic [1:0]  cnt;

   assign hdr_words = op_words(CMD_RDATA[31:24]);
   assign cnt       = (idx == 2'd0) ? hdr_words : nwords;

   always_comb begin
      next_state = state;
      CMD_RD_EN  = 1'b0;
      OP_VALID   = 1'b0;
      DRAW_END   = 1'b0;
      case (state)
         S_IDLE: begin
            if (EXE && !CMD_EMPTY)
               next_state = S_RDREQ;
         end
         S_RDREQ: begin
            // EXE is deliberately not checked: a started command always completes.
            CMD_RD_EN = !CMD_EMPTY;
            if (!CMD_EMPTY)
               next_state = S_RDWAIT;
         end
         S_RDWAIT: begin
            if (idx == 2'd0 && hdr_words == 2'd0)
               next_state = S_ERR;
            else if ({1'b0, idx} + 3'd1 < {1'b0, cnt})
               next_state = S_RDREQ;
            else
               next_state = S_EXEC;
         end
         S_EXEC: begin
            if (OP_CODE == OP_NOP) begin
               next_state = S_NEXT;
            end else if (OP_CODE == OP_EODL) begin
               DRAW_END   = 1'b1;
               next_state = S_IDLE;
            end else begin
               OP_VALID = 1'b1;
               if (OP_READY)
                  next_state = S_NEXT;
            end
         end
         S_NEXT: begin
            next_state = (EXE && !CMD_EMPTY) ? S_RDREQ : S_IDLE;
         end
         S_ERR: begin
            next_state = S_ERR;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         state     <= S_IDLE;
         DRAW_BUSY <= 1'b0;
      end else if (SOFT_RST) begin
         state     <= S_IDLE;
         DRAW_BUSY <= 1'b0;
      end else begin
         state     <= next_state;
         DRAW_BUSY <= !(next_state inside {S_IDLE, S_ERR});
      end
   end

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         idx     <= 2'd0;
         nwords  <= 2'd0;
         OP_CODE <= 8'h00;
         OP_ARG0 <= 32'h0;
         OP_ARG1 <= 32'h0;
         CMD_ERR <= 1'b0;
      end else if (SOFT_RST) begin
         idx     <= 2'd0;
         nwords  <= 2'd0;
         OP_CODE <= 8'h00;
         OP_ARG0 <= 32'h0;
         OP_ARG1 <= 32'h0;
         CMD_ERR <= 1'b0;
      end else begin
         case (state)
            S_RDWAIT: begin
               idx <= idx + 2'd1;
               case (idx)
                  2'd0: begin
                     OP_CODE <= CMD_RDATA[31:24];
                     nwords  <= hdr_words;
                     // Header payload is only meaningful for single-word commands.
                     OP_ARG0 <= (hdr_words == 2'd1) ? {8'h00, CMD_RDATA[23:0]} : 32'h0;
                     OP_ARG1 <= 32'h0;
                     if (hdr_words == 2'd0)
                        CMD_ERR <= 1'b1;
                  end
                  2'd1:    OP_ARG0 <= CMD_RDATA;
                  2'd2:    OP_ARG1 <= CMD_RDATA;
                  default: ;
               endcase
            end
            S_IDLE, S_NEXT: idx <= 2'd0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_cmd_decoder.sv
// Directed bench: behavioural non-FWFT FIFO feeding the decoder, checks against hand-derived values.
module tb_draw_cmd_decoder;

   logic        CLK;
   logic        ARST;
   logic        SOFT_RST;
   logic        EXE;
   logic        CMD_RD_EN;
   logic [31:0] CMD_RDATA;
   logic        CMD_EMPTY;
   logic        OP_VALID;
   logic        OP_READY;
   logic [7:0]  OP_CODE;
   logic [31:0] OP_ARG0;
   logic [31:0] OP_ARG1;
   logic        DRAW_BUSY;
   logic        DRAW_END;
   logic        CMD_ERR;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] fmem [0:63];
   int wr_ptr = 0;
   int rd_ptr;
   int pop_cnt;
   int xfer_cnt;
   int bad_pop;

   draw_cmd_decoder dut (
      .CLK       (CLK),
      .ARST      (ARST),
      .SOFT_RST  (SOFT_RST),
      .EXE       (EXE),
      .CMD_RD_EN (CMD_RD_EN),
      .CMD_RDATA (CMD_RDATA),
      .CMD_EMPTY (CMD_EMPTY),
      .OP_VALID  (OP_VALID),
      .OP_READY  (OP_READY),
      .OP_CODE   (OP_CODE),
      .OP_ARG0   (OP_ARG0),
      .OP_ARG1   (OP_ARG1),
      .DRAW_BUSY (DRAW_BUSY),
      .DRAW_END  (DRAW_END),
      .CMD_ERR   (CMD_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign CMD_EMPTY = (wr_ptr == rd_ptr);

   always @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         rd_ptr    <= 0;
         CMD_RDATA <= 32'h0;
         pop_cnt   <= 0;
         xfer_cnt  <= 0;
         bad_pop   <= 0;
      end else begin
         if (SOFT_RST) begin
            rd_ptr <= wr_ptr;
         end else if (CMD_RD_EN) begin
            if (CMD_EMPTY) begin
               bad_pop <= bad_pop + 1;
            end else begin
               CMD_RDATA <= fmem[rd_ptr[5:0]];
               rd_ptr    <= rd_ptr + 1;
               pop_cnt   <= pop_cnt + 1;
            end
         end
         if (OP_VALID && OP_READY)
            xfer_cnt <= xfer_cnt + 1;
      end
   end

   task automatic push(input logic [31:0] w);
      fmem[wr_ptr[5:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!OP_VALID && n < 60);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int p0;
      int x0;
      logic busy_low;
      logic stable;

      ARST     = 1'b1;
      SOFT_RST = 1'b0;
      EXE      = 1'b0;
      OP_READY = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_busy",  32'(DRAW_BUSY), 32'd0);
      check("rst_valid", 32'(OP_VALID),  32'd0);
      check("rst_rden",  32'(CMD_RD_EN), 32'd0);
      check("rst_err",   32'(CMD_ERR),   32'd0);
      check("rst_end",   32'(DRAW_END),  32'd0);
      check("rst_code",  {24'h0, OP_CODE}, 32'h0);
      check("rst_arg0",  OP_ARG0, 32'h0);
      check("rst_arg1",  OP_ARG1, 32'h0);
      ARST = 1'b0;
      @(negedge CLK);

      // SETFRAME with ready tied high
      p0 = pop_cnt; x0 = xfer_cnt;
      push(32'h20000000); push(32'h10000000); push(32'h01E00280);
      EXE = 1'b1; OP_READY = 1'b1;
      n = 0; busy_low = 1'b0;
      do begin
         @(negedge CLK);
         n++;
         if (!DRAW_BUSY) busy_low = 1'b1;
      end while (!OP_VALID && n < 60);
      check("t1_latency", 32'(n), 32'd7);
      check("t1_code", {24'h0, OP_CODE}, 32'h20);
      check("t1_arg0", OP_ARG0, 32'h10000000);
      check("t1_arg1", OP_ARG1, 32'h01E00280);
      check("t1_busy_throughout", 32'(busy_low), 32'd0);
      @(negedge CLK);
      check("t1_valid_drop", 32'(OP_VALID), 32'd0);
      check("t1_busy_next", 32'(DRAW_BUSY), 32'd1);
      @(negedge CLK);
      check("t1_busy_idle", 32'(DRAW_BUSY), 32'd0);
      check("t1_xfers", 32'(xfer_cnt - x0), 32'd1);
      check("t1_pops", 32'(pop_cnt - p0), 32'd3);

      // SETFCOLOR followed by EODL
      p0 = pop_cnt; x0 = xfer_cnt;
      push(32'h22000000); push(32'h00FF0000); push(32'h0F000000);
      wait_valid(n);
      check("t2_code", {24'h0, OP_CODE}, 32'h22);
      check("t2_arg0", OP_ARG0, 32'h00FF0000);
      check("t2_arg1", OP_ARG1, 32'h0);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!DRAW_END && n < 20);
      check("t2_end_latency", 32'(n), 32'd4);
      check("t2_end_novalid", 32'(OP_VALID), 32'd0);
      check("t2_end_busy", 32'(DRAW_BUSY), 32'd1);
      @(negedge CLK);
      check("t2_end_pulse", 32'(DRAW_END), 32'd0);
      check("t2_busy_after", 32'(DRAW_BUSY), 32'd0);
      check("t2_xfers", 32'(xfer_cnt - x0), 32'd1);
      check("t2_pops", 32'(pop_cnt - p0), 32'd3);

      // PATBLT with arguments delayed, then a stalled handshake
      p0 = pop_cnt;
      push(32'h81000000);
      repeat (20) @(negedge CLK);
      check("t3_rden_starved", 32'(CMD_RD_EN), 32'd0);
      check("t3_busy_starved", 32'(DRAW_BUSY), 32'd1);
      check("t3_pops_starved", 32'(pop_cnt - p0), 32'd1);
      check("t3_valid_starved", 32'(OP_VALID), 32'd0);
      OP_READY = 1'b0;
      push(32'h00100020); push(32'h00300040);
      wait_valid(n);
      check("t3_valid_seen", 32'(OP_VALID), 32'd1);
      check("t3_code", {24'h0, OP_CODE}, 32'h81);
      check("t3_arg0", OP_ARG0, 32'h00100020);
      check("t3_arg1", OP_ARG1, 32'h00300040);
      push(32'h00000000);
      x0 = xfer_cnt;
      stable = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         if (!OP_VALID || OP_CODE != 8'h81 || OP_ARG0 != 32'h00100020 || OP_ARG1 != 32'h00300040)
            stable = 1'b0;
      end
      check("t4_stall_stable", 32'(stable), 32'd1);
      check("t4_stall_pops", 32'(pop_cnt - p0), 32'd3);
      check("t4_stall_xfers", 32'(xfer_cnt - x0), 32'd0);
      OP_READY = 1'b1;
      @(negedge CLK);
      check("t4_valid_drop", 32'(OP_VALID), 32'd0);
      check("t4_one_xfer", 32'(xfer_cnt - x0), 32'd1);
      repeat (10) @(negedge CLK);
      check("t4_nop_no_xfer", 32'(xfer_cnt - x0), 32'd1);
      check("t4_nop_popped", 32'(pop_cnt - p0), 32'd4);
      check("t4_busy_idle", 32'(DRAW_BUSY), 32'd0);

      // Unknown opcode
      p0 = pop_cnt;
      push(32'h55000000); push(32'h20000000);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!CMD_ERR && n < 20);
      check("t5_err_latency", 32'(n), 32'd3);
      check("t5_err_busy", 32'(DRAW_BUSY), 32'd0);
      repeat (10) @(negedge CLK);
      check("t5_err_pops", 32'(pop_cnt - p0), 32'd1);
      check("t5_err_rden", 32'(CMD_RD_EN), 32'd0);
      check("t5_err_sticky", 32'(CMD_ERR), 32'd1);
      SOFT_RST = 1'b1;
      @(negedge CLK);
      SOFT_RST = 1'b0;
      check("t5_srst_err", 32'(CMD_ERR), 32'd0);
      check("t5_srst_busy", 32'(DRAW_BUSY), 32'd0);
      check("t5_srst_code", {24'h0, OP_CODE}, 32'h0);
      repeat (5) @(negedge CLK);
      check("t5_idle_busy", 32'(DRAW_BUSY), 32'd0);
      check("t5_idle_pops", 32'(pop_cnt - p0), 32'd1);

      // Soft reset in the middle of a handshake
      OP_READY = 1'b0;
      push(32'h23000000); push(32'h00000001); push(32'h00000002);
      wait_valid(n);
      check("t5b_valid", 32'(OP_VALID), 32'd1);
      SOFT_RST = 1'b1;
      @(negedge CLK);
      SOFT_RST = 1'b0;
      OP_READY = 1'b1;
      check("t5b_valid_drop", 32'(OP_VALID), 32'd0);
      check("t5b_arg0_clr", OP_ARG0, 32'h0);
      @(negedge CLK);

      // EXE dropped after a header pop
      p0 = pop_cnt;
      push(32'h81000000);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (pop_cnt == p0 && n < 20);
      EXE = 1'b0;
      push(32'h00000005); push(32'h00000006); push(32'h22000000); push(32'h00000077);
      wait_valid(n);
      check("t6_code", {24'h0, OP_CODE}, 32'h81);
      check("t6_arg0", OP_ARG0, 32'h00000005);
      check("t6_arg1", OP_ARG1, 32'h00000006);
      repeat (10) @(negedge CLK);
      check("t6_parked_busy", 32'(DRAW_BUSY), 32'd0);
      check("t6_parked_pops", 32'(pop_cnt - p0), 32'd3);
      EXE = 1'b1;
      wait_valid(n);
      check("t6_resume_code", {24'h0, OP_CODE}, 32'h22);
      check("t6_resume_arg0", OP_ARG0, 32'h00000077);
      repeat (5) @(negedge CLK);
      check("t6_resume_pops", 32'(pop_cnt - p0), 32'd5);
      check("t6_resume_idle", 32'(DRAW_BUSY), 32'd0);

      check("empty_pops", 32'(bad_pop), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/draw_cmd_decoder.md
Name: draw_cmd_decoder

Overview:
- Downstream consumer of the drawing command FIFO in the draw IP.
- While execution is enabled, pops 32-bit command words from the FIFO and decodes the opcode. Collects the argument words for that opcode and hands one complete command to the draw engine over a valid/ready handshake.
- Generates the BUSY status and the end-of-list pulse that the register block turns into DRW_IRQ.

Parameters:
- NUM_OPS, 8, number of entries in the opcode table (fixed by the package; informational only).

Ports:
- CLK  in  1  system clock
- ARST  in  1  asynchronous active-high reset
- SOFT_RST  in  1  synchronous soft reset from the register block (REG_RST)
- EXE  in  1  execute enable level from the register block (REG_EXE)
- CMD_RD_EN  out  1  FIFO pop strobe
- CMD_RDATA  in  32  FIFO read data; valid the cycle after CMD_RD_EN (standard, non-FWFT)
- CMD_EMPTY  in  1  FIFO empty flag
- OP_VALID  out  1  decoded command valid
- OP_READY  in  1  draw engine accepts the command
- OP_CODE  out  8  decoded opcode
- OP_ARG0  out  32  first argument word
- OP_ARG1  out  32  second argument word
- DRAW_BUSY  out  1  decoder active (status bit DRAWSTAT[0])
- DRAW_END  out  1  one-cycle pulse when an EODL command is executed
- CMD_ERR  out  1  sticky error: unknown opcode

Behaviour:
- Reset (ARST async, or SOFT_RST sync):
  - State goes to S_IDLE.
  - All outputs are 0; OP_ARG0, OP_ARG1 and OP_CODE are 0; CMD_ERR is cleared.
- Word format: opcode = word[31:24]. Total words per command, header included:
  - NOP 0x00: 1 word
  - EODL 0x0F: 1 word
  - SETFRAME 0x20: 3 words
  - SETDRAWAREA 0x21: 3 words
  - SETFCOLOR 0x22: 2 words
  - PATBLT 0x81: 3 words
  - BITBLT 0x82: 3 words
  - SETSRC 0x23: 3 words
- The header word's [23:0] is carried in OP_ARG0 only for 1-word commands; it is otherwise ignored.
- States:
  - S_IDLE: if EXE && !CMD_EMPTY, go to S_RDREQ. DRAW_BUSY is 0.
  - S_RDREQ: CMD_RD_EN = !CMD_EMPTY. This is combinational from state and CMD_EMPTY, so it can never pop an empty FIFO. On a pop, go to S_RDWAIT. If the FIFO is empty, stay in S_RDREQ with BUSY still 1, including in the middle of a command.
  - S_RDWAIT: capture CMD_RDATA by 2-bit word index idx:
    - idx 0: latch the opcode and look up the word count. For an unknown opcode, set CMD_ERR and go to S_ERR.
    - idx 1: into ARG0.
    - idx 2: into ARG1.
    - Then increment idx. If idx+1 < word count, go to S_RDREQ; otherwise go to S_EXEC.
  - S_EXEC, per opcode:
    - NOP: no output; go to S_NEXT.
    - EODL: DRAW_END = 1 for this cycle; go to S_IDLE.
    - Others: OP_VALID = 1. OP_CODE, OP_ARG0 and OP_ARG1 hold stable until OP_READY. Transfer happens on the cycle with OP_VALID && OP_READY; then go to S_NEXT.
  - S_NEXT: clear idx. If EXE && !CMD_EMPTY go to S_RDREQ; otherwise go to S_IDLE.
  - S_ERR: BUSY = 0, no pops, CMD_ERR = 1. Exit only via SOFT_RST or ARST.
- DRAW_BUSY = 1 in every state except S_IDLE and S_ERR. It is registered from state, so it is high from the cycle after leaving S_IDLE.
- EXE deasserted mid-command: the current command is completed, including waiting on the FIFO and the handshake. The decoder then parks in S_IDLE. Restarting resumes at the next header.
- Minimum latency: 2 cycles per word plus 1 S_EXEC cycle plus 1 S_NEXT cycle. Example: a 3-word command with OP_READY tied to 1 takes 8 cycles from the first pop to the next pop.
- OP_READY is ignored when OP_VALID = 0.
- SOFT_RST during a handshake drops OP_VALID the next cycle. Any partially collected command is discarded; the FIFO is cleared by the same reset.

Decomposition:
- Package draw_cmd_pkg:
  - opcode localparams
  - typedef enum state_t
  - function op_words(opcode) returning 0 for unknown opcodes
- No sub-module; a single FSM plus argument registers.

Test Plan:
- FIFO holds {0x20000000, 0x10000000, 0x01E00280}, EXE=1, OP_READY=1 -> one OP_VALID pulse with OP_CODE=0x20, ARG0=0x10000000, ARG1=0x01E00280; BUSY high throughout; returns to S_IDLE with BUSY=0.
- FIFO holds {0x22000000, 0x00FF0000, 0x0F000000} -> SETFCOLOR issued with ARG0=0x00FF0000, then a DRAW_END 1-cycle pulse; BUSY=0 the cycle after.
- PATBLT header written, then args delayed 20 cycles -> stays in S_RDREQ with CMD_RD_EN=0 and BUSY=1; completes when args arrive.
- OP_READY held 0 for 10 cycles -> OP_VALID and args stable for all 10 cycles; exactly one transfer on the first READY=1 cycle; no pops during the stall.
- Header 0x55000000 -> CMD_ERR=1, BUSY=0, no further pops despite a non-empty FIFO; SOFT_RST pulse -> CMD_ERR=0, back in S_IDLE.
- EXE dropped after a PATBLT header pop -> the command completes, then S_IDLE; with EXE=0 the remaining FIFO words are untouched; EXE=1 resumes decoding.
